data_memory_ws: RTL and testbench
=================================

// Module: data_memory_ws
// PURPOSE
//  Parametrised, clocked data memory for the MIPS datapath. Replaces the combinational
//  8-bit tri-state memory with separate read/write buses, byte-lane write enables and a
//  programmable wait-state controller with a ready handshake.
//  Sits between the MEM-stage control (MemRead/MemWrite) and the register write-back mux.
// PARAMETERS
//  DATA_W       32    data width in bits; multiple of 8; DATA_W/8 is a power of 2
//  ADDR_W       12    byte-address width
//  DEPTH_WORDS  1024  number of DATA_W words implemented; must be <= 2**(ADDR_W-log2(DATA_W/8))
//  WAIT_CYCLES  2     wait states inserted before completion (0..15)
// PORTS
//  clk            in   1         rising-edge clock
//  rst            in   1         asynchronous, active-high reset
//  MemRead        in   1         read request
//  MemWrite       in   1         write request
//  inAddress      in   ADDR_W    byte address
//  inWriteData    in   DATA_W    write data
//  inByteEn       in   DATA_W/8  write byte-lane enables; bit i -> bits [8i+7:8i]
//  outReadData    out  DATA_W    registered read data
//  outReady       out  1         1-cycle completion pulse (read data valid / write committed)
//  outBusy        out  1         high while an access is outstanding (WAIT or DONE)
//  outMisaligned  out  1         1-cycle pulse alongside outReady for a rejected misaligned access
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0, outReadData=0, outReady=0, outBusy=0,
//    outMisaligned=0. Memory array is not cleared; an access in flight is aborted and no write commits.
//  - FSM: IDLE -> WAIT -> DONE -> IDLE.
//    IDLE: request accepted when MemRead|MemWrite=1 on a clock edge; latch op, address,
//      write data and byte enables; counter<=WAIT_CYCLES; go to WAIT (DONE if WAIT_CYCLES=0).
//    WAIT: counter decrements each cycle; at counter==1 go to DONE.
//    DONE: outReady=1 for exactly one cycle, then return to IDLE.
//  - Latency: request edge to outReady high = WAIT_CYCLES+1 cycles. Back-to-back
//    throughput: one access per WAIT_CYCLES+2 cycles (accept only in IDLE).
//  - Requests while outBusy=1 are ignored; they are not queued.
//  - MemRead and MemWrite both high: treated as a write; the read is discarded.
//  - Write commits on the edge entering DONE, only to lanes with inByteEn=1. Other lanes keep
//    their values; inByteEn=0 commits nothing but still handshakes.
//  - Read: outReadData loaded on the edge entering DONE; held until the next completed read.
//    A write does not change outReadData.
//  - Word index = inAddress[ADDR_W-1:log2(DATA_W/8)]. Index >= DEPTH_WORDS: write dropped,
//    read returns 0, and the handshake completes normally (no wrap-around).
//  - Read-after-write to the same word in consecutive accesses returns the new data.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN
//   defined: an access whose low log2(DATA_W/8) address bits are non-zero is rejected. No write
//     commits, outReadData is unchanged, and outMisaligned pulses together with outReady.
//   undefined: the low address bits are ignored (word-aligned access); outMisaligned is tied to 0.
// TESTING (defaults, WAIT_CYCLES=2)
//  1 rst=1 mid-WAIT of a write 0xDEADBEEF @0x010 -> outputs 0 at once; a later read @0x010 does not return 0xDEADBEEF
//  2 write 0x11223344 @0x020, BE=4'b1111, then read @0x020 -> outReady 3 cycles after each
//    request; read returns 0x11223344
//  3 write 0xAABBCCDD @0x020, BE=4'b0101, then read -> 0x11BB33DD
//  4 read with MemRead held high during WAIT/DONE -> exactly one outReady per accept, gap of 4
//    cycles between accepts; MemRead=MemWrite=1 with data 0x5 @0x030 -> a read of 0x030 returns 0x5
//  5 read @0xFFC (index 1023) after writing 0x0F0F0F0F -> 0x0F0F0F0F; with DEPTH_WORDS=512 the
//    same read -> 0x00000000 and the write has no effect
//  6 DMEM_ALIGN_CHECK_EN: write @0x022 -> outMisaligned=outReady=1 and memory unchanged; without the
//    macro, the same write lands at word 0x020

Source files
------------

// File: rtl/data_memory_ws.sv
// data_memory_ws -- clocked MIPS data memory with byte-lane writes and a
// programmable wait-state handshake.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   MemRead         read request
//   MemWrite        write request (wins when both requests are high)
//   inAddress       byte address
//   inWriteData     write data
//   inByteEn        per-byte write enables, bit i -> bits [8i+7:8i]
//   outReadData     registered read data, held until the next completed read
//   outReady        one-cycle completion pulse
//   outBusy         high while an access is outstanding
//   outMisaligned   pulses with outReady when a misaligned access is rejected
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses whose low
// address bits are non-zero (needs DATA_W >= 16). Without it those bits are
// ignored and outMisaligned stays 0.
//
// A request is taken only in IDLE. The FSM walks IDLE -> WAIT -> DONE -> IDLE
// (IDLE -> DONE when WAIT_CYCLES is 0); memory writes and read-data loads both
// happen on the edge that enters DONE. The memory array itself is never reset.

// One byte lane of the storage array: synchronous write, asynchronous read.
module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    q
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign q = mem[addr];
endmodule

module data_memory_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   inAddress,
  input  logic [DATA_W-1:0]   inWriteData,
  input  logic [DATA_W/8-1:0] inByteEn,
  output logic [DATA_W-1:0]   outReadData,
  output logic                outReady,
  output logic                outBusy,
  output logic                outMisaligned
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF    = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // one extra bit so DEPTH_WORDS == 2**IDX_W is representable
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, nxt;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [NB-1:0]     op_be;

  logic              acc, commit, in_range, c_wr, c_mis;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [NB-1:0]     c_be;
  logic [IDX_W-1:0]  c_idx;
  logic [NB-1:0]     lane_we;
  logic [NB-1:0][7:0] lane_q;

  // next state / accept
  always_comb begin
    nxt = state;
    acc = 1'b0;
    case (state)
      S_IDLE: if (MemRead | MemWrite) begin
        acc = 1'b1;
        nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (cnt == 4'd1) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // With zero wait states DONE is entered straight from IDLE, before the
  // request has been latched, so the operation is taken from the live inputs.
  always_comb begin
    c_wr   = op_wr;
    c_addr = op_addr;
    c_data = op_data;
    c_be   = op_be;
    if (state == S_IDLE) begin
      c_wr   = MemWrite;
      c_addr = inAddress;
      c_data = inWriteData;
      c_be   = inByteEn;
    end
  end

  assign c_idx    = c_addr[ADDR_W-1:OFF];
  assign in_range = {1'b0, c_idx} < DEPTH_L;
  assign commit   = (nxt == S_DONE) && (state != S_DONE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign c_mis = |c_addr[OFF-1:0];
`else
  logic unused_lo;
  assign c_mis     = 1'b0;
  assign unused_lo = ^c_addr[OFF-1:0];
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_we[i] = commit & c_wr & c_be[i] & in_range & ~c_mis;
    dmem_lane #(.DEPTH(DEPTH_WORDS), .AW(MEM_AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .addr  (c_idx[MEM_AW-1:0]),
      .wdata (c_data[8*i +: 8]),
      .q     (lane_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      op_addr     <= '0;
      op_data     <= '0;
      op_be       <= '0;
      outReadData <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        cnt     <= 4'(WAIT_CYCLES);
        op_wr   <= MemWrite;
        op_addr <= inAddress;
        op_data <= inWriteData;
        op_be   <= inByteEn;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // out-of-range reads complete with zero rather than wrapping
      if (commit && !c_wr && !c_mis)
        outReadData <= in_range ? lane_q : '0;
    end
  end

  assign outReady      = (state == S_DONE);
  assign outBusy       = (state != S_IDLE);
  assign outMisaligned = (state == S_DONE) && c_mis;
endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws -- directed bench for data_memory_ws. Two instances share
// the stimulus: the default 1024-word memory and a 512-word one. A transaction
// level model (busy countdown plus a byte-addressed associative memory)
// predicts every output each cycle; literal expectations pin the model.
module tb_data_memory_ws;
  localparam int W = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [11:0] inAddress = '0;
  logic [31:0] inWriteData = '0;
  logic [3:0]  inByteEn = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, bsy0, bsy1, mis0, mis1;

  always #5 clk = ~clk;

  data_memory_ws #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .inAddress(inAddress), .inWriteData(inWriteData), .inByteEn(inByteEn),
    .outReadData(rd0), .outReady(rdy0), .outBusy(bsy0), .outMisaligned(mis0));

  data_memory_ws #(.DEPTH_WORDS(512), .WAIT_CYCLES(W)) dut_s (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .inAddress(inAddress), .inWriteData(inWriteData), .inByteEn(inByteEn),
    .outReadData(rd1), .outReady(rdy1), .outBusy(bsy1), .outMisaligned(mis1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          depth [2] = '{1024, 512};
  int          cnt   [2] = '{0, 0};    // busy cycles left; 1 == completion cycle
  logic        p_wr  [2];
  logic [11:0] p_a   [2];
  logic [31:0] p_d   [2];
  logic [3:0]  p_be  [2];
  logic        m_mis [2] = '{1'b0, 1'b0};
  logic [31:0] m_rd  [2] = '{32'h0, 32'h0};
  logic        known [2] = '{1'b1, 1'b1};
  logic [7:0]  mmem  [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0; m_rd[k] = 32'h0; known[k] = 1'b1; m_mis[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cnt[k] > 0) cnt[k]--;
        else if (MemRead || MemWrite) begin
          cnt[k] = W + 1;
          p_wr[k] = MemWrite; p_a[k] = inAddress; p_d[k] = inWriteData; p_be[k] = inByteEn;
        end
        if (cnt[k] == 1) begin
          int widx;
          widx = int'(p_a[k]) / 4;
          m_mis[k] = ALIGN && (p_a[k] % 4 != 0);
          if (!m_mis[k]) begin
            if (p_wr[k]) begin
              if (widx < depth[k])
                for (int b = 0; b < 4; b++)
                  if (p_be[k][b]) mmem[k*4096 + widx*4 + b] = p_d[k][8*b +: 8];
            end else if (widx < depth[k]) begin
              known[k] = 1'b1;
              for (int b = 0; b < 4; b++)
                if (mmem.exists(k*4096 + widx*4 + b)) m_rd[k][8*b +: 8] = mmem[k*4096 + widx*4 + b];
                else known[k] = 1'b0;
            end else begin
              m_rd[k] = 32'h0; known[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    chk("ready0", {31'b0, rdy0}, {31'b0, cnt[0] == 1});
    chk("busy0",  {31'b0, bsy0}, {31'b0, cnt[0] > 0});
    chk("mis0",   {31'b0, mis0}, {31'b0, cnt[0] == 1 && m_mis[0]});
    chk("ready1", {31'b0, rdy1}, {31'b0, cnt[1] == 1});
    chk("busy1",  {31'b0, bsy1}, {31'b0, cnt[1] > 0});
    chk("mis1",   {31'b0, mis1}, {31'b0, cnt[1] == 1 && m_mis[1]});
    if (known[0]) chk("rdata0", rd0, m_rd[0]);
    if (known[1]) chk("rdata1", rd1, m_rd[1]);
  end

  // ---------------- stimulus ----------------
  task automatic access(input logic r, input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic mis, output logic [31:0] q0, output logic [31:0] q1);
    MemRead = r; MemWrite = w; inAddress = a; inWriteData = d; inByteEn = be;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin MemRead = 1'b0; MemWrite = 1'b0; end
    end while (!rdy0 && lat < 20);
    mis = mis0; q0 = rd0; q1 = rd1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string name, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    int lat; logic mis; logic [31:0] q0, q1;
    access(1'b0, 1'b1, a, d, be, lat, mis, q0, q1);
    chk({name, "_lat"}, lat, W + 1);
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] e0, input logic [31:0] e1);
    int lat; logic mis; logic [31:0] q0, q1;
    access(1'b1, 1'b0, a, 32'h0, 4'h0, lat, mis, q0, q1);
    chk({name, "_lat"}, lat, W + 1);
    chk({name, "_q0"}, q0, e0);
    chk({name, "_q1"}, q1, e1);
  endtask

  initial begin
    int          t[$];
    int          lat;
    logic        mis;
    logic [31:0] q0, q1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, rdy0}, 32'h0);
    chk("rst_busy",  {31'b0, bsy0}, 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_mis",   {31'b0, mis0}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset in the middle of a write aborts it
    wr("pre10", 12'h010, 32'h01010101, 4'hF);
    MemWrite = 1'b1; inAddress = 12'h010; inWriteData = 32'hDEADBEEF; inByteEn = 4'hF;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    chk("midwait_busy", {31'b0, bsy0}, 32'h1);
    rst = 1'b1; #1;
    chk("abort_ready", {31'b0, rdy0}, 32'h0);
    chk("abort_busy",  {31'b0, bsy0}, 32'h0);
    chk("abort_rdata", rd0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd("rd10", 12'h010, 32'h01010101, 32'h01010101);

    // 2, 3: full-word then partial-lane write
    wr("w20", 12'h020, 32'h11223344, 4'hF);
    rd("rd20", 12'h020, 32'h11223344, 32'h11223344);
    wr("w20be", 12'h020, 32'hAABBCCDD, 4'b0101);
    rd("rd20be", 12'h020, 32'h11BB33DD, 32'h11BB33DD);

    // 4: request held high is accepted once per access
    MemRead = 1'b1; inAddress = 12'h020;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 9) MemRead = 1'b0;
      if (rdy0) t.push_back(e);
    end
    chk("held_pulses", t.size(), 3);
    if (t.size() == 3) begin
      chk("held_gap1", t[1] - t[0], 4);
      chk("held_gap2", t[2] - t[1], 4);
    end
    access(1'b1, 1'b1, 12'h030, 32'h5, 4'hF, lat, mis, q0, q1);
    chk("rw_lat", lat, W + 1);
    chk("rw_keeps_rdata", q0, 32'h11BB33DD);
    rd("rd30", 12'h030, 32'h5, 32'h5);

    // 5: top word; the small instance drops it and does not wrap
    wr("w7fc", 12'h7FC, 32'h12345678, 4'hF);
    wr("wffc", 12'hFFC, 32'h0F0F0F0F, 4'hF);
    rd("rdffc", 12'hFFC, 32'h0F0F0F0F, 32'h00000000);
    rd("rd7fc", 12'h7FC, 32'h12345678, 32'h12345678);

    // 6: misaligned write
    access(1'b0, 1'b1, 12'h022, 32'hCAFEF00D, 4'hF, lat, mis, q0, q1);
    chk("mis_lat", lat, W + 1);
    chk("mis_flag", {31'b0, mis}, {31'b0, ALIGN});
    rd("rd20mis", 12'h020, ALIGN ? 32'h11BB33DD : 32'hCAFEF00D,
                           ALIGN ? 32'h11BB33DD : 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
